// File: rtl/reg_file_if.sv
// reg_file_if -- bundle of the register file's write and read-pair signals.
//
// Signals:
//   wr_enable, wr_addr, wr_data : write strobe, address and data
//   rd_req, rd_addr_a, rd_addr_b: read request and the two read addresses
//   rd_accept                   : register file can take a read this cycle
//   rd_valid                    : output pair holds a result
//   rd_ready                    : consumer takes the output pair this cycle
//   rd_data_a, rd_data_b        : registered read results
//
// Modports: slave = the register file, master = the agent driving it.
interface reg_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              wr_enable;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              rd_accept;
    logic              rd_valid;
    logic              rd_ready;
    logic [WIDTH-1:0]  rd_data_a;
    logic [WIDTH-1:0]  rd_data_b;

    modport slave (
        input  wr_enable, wr_addr, wr_data,
        input  rd_req, rd_addr_a, rd_addr_b, rd_ready,
        output rd_accept, rd_valid, rd_data_a, rd_data_b
    );

    modport master (
        output wr_enable, wr_addr, wr_data,
        output rd_req, rd_addr_a, rd_addr_b, rd_ready,
        input  rd_accept, rd_valid, rd_data_a, rd_data_b
    );
endinterface

// File: rtl/reg_file.sv
// reg_file -- 2**ADDR_W x WIDTH register file, one write port and a
// two-address read port whose results are held in a one-deep output
// register with a valid/ready handshake. Address 0 is hard-wired to zero.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-low reset, clears all state
//   bus   : reg_file_if slave modport (write port, read request, read pair)
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_data_a;
    logic [WIDTH-1:0] r_data_b;
    logic             w_accept;
    logic             w_take;
    logic             w_wr_live;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // A write to address 0 is a no-op, so it must not feed the bypass either.
    assign w_wr_live = bus.wr_enable && (bus.wr_addr != '0);

    // Read values: zero register, then same-cycle write bypass, then array.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        if (bus.rd_addr_a != '0) begin
            if (w_wr_live && (bus.wr_addr == bus.rd_addr_a))
                w_rd_a = bus.wr_data;
            else
                w_rd_a = r_mem[bus.rd_addr_a];
        end
        if (bus.rd_addr_b != '0) begin
            if (w_wr_live && (bus.wr_addr == bus.rd_addr_b))
                w_rd_b = bus.wr_data;
            else
                w_rd_b = r_mem[bus.rd_addr_b];
        end
    end

    // Output-stage FSM: next state and handshake.
    always_comb begin
        w_accept    = (r_state == ST_EMPTY) || bus.rd_ready;
        w_take      = bus.rd_req && w_accept;
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_take)
                    w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (w_take)
                    w_state_nxt = ST_FULL;
                else if (bus.rd_ready)
                    w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Output pair is loaded only on a taken read, so a stalled FULL pair is a
    // snapshot that later writes cannot disturb.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else if (w_take) begin
            r_data_a <= w_rd_a;
            r_data_b <= w_rd_b;
        end
    end

    // Entry 0 is never written; it is cleared by reset and read as zero anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_live) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.rd_accept = w_accept;
    assign bus.rd_valid  = (r_state == ST_FULL);
    assign bus.rd_data_a = r_data_a;
    assign bus.rd_data_b = r_data_b;
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register.
REQ-002 Parameter ADDR_W, default 5, address width; depth SHALL be 2**ADDR_W registers.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low SHALL clear all state immediately, independent of clk.
REQ-005 wr_enable  input  1  write strobe, sampled on rising edge.
REQ-006 wr_addr  input  ADDR_W  write address.
REQ-007 wr_data  input  WIDTH  write data.
REQ-008 rd_req  input  1  read request, both ports read together.
REQ-009 rd_addr_a  input  ADDR_W  port A read address.
REQ-010 rd_addr_b  input  ADDR_W  port B read address.
REQ-011 rd_accept  output  1  combinational; high when a read request can be taken this cycle.
REQ-012 rd_valid  output  1  registered; output pair holds a valid result.
REQ-013 rd_ready  input  1  consumer accepts the output pair this cycle.
REQ-014 rd_data_a  output  WIDTH  registered port A result.
REQ-015 rd_data_b  output  WIDTH  registered port B result.

Function
REQ-016 Output stage SHALL be a two-state FSM: EMPTY (rd_valid=0) and FULL (rd_valid=1).
REQ-017 rd_accept SHALL equal (state==EMPTY) or rd_ready.
REQ-018 A read SHALL be taken when rd_req and rd_accept are both high; the next state SHALL be FULL and rd_data_a/b SHALL be loaded with the read results, giving a latency of one cycle.
REQ-019 EMPTY->FULL on a taken read; FULL->EMPTY on rd_ready with no taken read; FULL->FULL, with new data, on rd_ready with a taken read; FULL with rd_ready low SHALL hold data and rd_valid unchanged.
REQ-020 rd_req while rd_accept is low SHALL be ignored; no request is queued.
REQ-021 Address 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-022 A write with wr_enable high and wr_addr!=0 SHALL update the register at the rising edge.
REQ-023 Bypass: a read taken in the same cycle as a write to the same non-zero address SHALL return wr_data on that port; both ports SHALL bypass independently.
REQ-024 Snapshot: once captured, rd_data_a/b SHALL NOT change due to later writes while FULL and stalled.
REQ-025 rd_addr_a equal to rd_addr_b SHALL return identical data on both ports.
REQ-026 Write and read paths SHALL be independent; a write SHALL proceed regardless of rd_accept or FSM state.
REQ-027 rd_data_a/b SHALL hold their last value when not loaded; no X SHALL appear on outputs after reset.

Reset
REQ-028 While reset is low, all registers SHALL be 0, the state SHALL be EMPTY, rd_valid SHALL be 0, and rd_data_a/b SHALL be 0.
REQ-029 Deassertion of reset SHALL take effect at the next rising edge; a write or read presented in that first cycle SHALL be honoured.
REQ-030 A reset asserted while FULL SHALL drop rd_valid immediately, without waiting for clk, and SHALL discard the pending pair.

Verification
REQ-031 After reset, read addresses 3 and 31 with rd_ready=1 -> one cycle later rd_valid=1, rd_data_a=0, rd_data_b=0.
REQ-032 Write 0xDEADBEEF to address 5, then next cycle read A=5, B=0 -> rd_data_a=0xDEADBEEF, rd_data_b=0.
REQ-033 Same cycle: write 0x12345678 to address 7 and read A=7, B=7 -> both outputs 0x12345678 (bypass); write 0xFFFFFFFF to address 0, then read A=0 -> 0.
REQ-034 Read address 5 (holding 0xDEADBEEF) with rd_ready=0 and hold 3 cycles; write 0x1 to address 5 during the hold -> rd_valid stays 1, rd_data_a stays 0xDEADBEEF, rd_accept=0, and a new rd_req is ignored.
REQ-035 Back-to-back reads of addresses 1, 2, 3 with rd_ready=1 every cycle -> rd_valid stays high with one result per cycle, in order; deassert rd_req -> rd_valid=0 the following cycle.
REQ-036 Assert reset mid-cycle while FULL -> rd_valid and rd_data_a/b go to 0 before the next edge, and a subsequent read of address 5 returns 0.
